// File: rtl/mailbox_rx_agent.sv
// -----------------------------------------------------------------------------
// mailbox_rx_agent
//
// Destination-core-side agent for one mailbox channel. When the channel raises
// its interrupt, the agent reads CTRL and then DATA over the channel register
// port. It buffers {mode, len, data} in a small FIFO. It then writes CTRL back
// with read_ok set and pulses clear_intr. The destination core drains the FIFO
// through a valid/ready interface.
//
// Messages whose mode field is 00 are not buffered. They are still
// acknowledged, and err_mode pulses for one cycle.
//
// Parameters
//   DEPTH       FIFO entries (power of two, >= 2)
//   AW          FIFO pointer width, log2(DEPTH)
//
// Ports
//   clk         clock
//   rstn        asynchronous active-low reset
//   en          agent enable; gates only the start of a new transaction
//   int_flag    channel interrupt (INT enable AND INT_bit)
//   ch_ren      channel read select, one-hot: 001 CTRL, 010 DATA, 100 STATUS
//   ch_rdata    channel read data, combinational from ch_ren
//   ch_wen      channel write select, same encoding as ch_ren
//   ch_wdata    channel write data
//   clear_intr  one-cycle pulse clearing the channel INT_bit
//   out_valid   FIFO head valid
//   out_ready   consumer accepts the head
//   out_data    head data word
//   out_mode    head mode: 01 data, 10 address, 11 command
//   out_len     head length field
//   fifo_count  FIFO occupancy
//   busy        a channel transaction is in progress
//   err_mode    one-cycle pulse when a mode-00 message is dropped
//
// CTRL layout: [31] INT enable, [30:29] mode, [28:15] len, [14] read_ok,
// [13:0] reserved.
// -----------------------------------------------------------------------------
module mailbox_rx_agent #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          int_flag,
  output logic [2:0]    ch_ren,
  input  logic [31:0]   ch_rdata,
  output logic [2:0]    ch_wen,
  output logic [31:0]   ch_wdata,
  output logic          clear_intr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [1:0]    out_mode,
  output logic [13:0]   out_len,
  output logic [AW:0]   fifo_count,
  output logic          busy,
  output logic          err_mode
);

  // Channel register selects (one-hot).
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_CTRL = 3'b001;
  localparam logic [2:0] SEL_DATA = 3'b010;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CTRL = 2'd1,
    RD_DATA = 2'd2,
    ACK     = 2'd3
  } state_t;

  // Only the upper CTRL fields matter. read_ok and the reserved bits are
  // regenerated on the write-back.
  typedef struct packed {
    logic        int_en;
    logic [1:0]  mode;
    logic [13:0] len;
  } ctrl_t;

  typedef struct packed {
    logic [1:0]  mode;
    logic [13:0] len;
    logic [31:0] data;
  } entry_t;

  state_t         state;
  ctrl_t          ctrl_q;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  logic           start;
  logic           push;
  logic           pop;

  // The full check is made only when leaving IDLE. At most one push can be
  // in flight, so the FIFO can never overflow.
  assign start = en && int_flag && (count < DEPTH_C);
  assign push  = (state == RD_DATA) && (ctrl_q.mode != 2'b00);
  assign pop   = out_valid && out_ready;

  assign out_valid  = (count != '0);
  assign fifo_count = count;
  assign busy       = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Control FSM. Every channel-side output is registered. Each output is
  // loaded on the edge that enters the state it belongs to, so it lines up
  // exactly with that state.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      ctrl_q     <= '0;
      ch_ren     <= SEL_NONE;
      ch_wen     <= SEL_NONE;
      ch_wdata   <= '0;
      clear_intr <= 1'b0;
      err_mode   <= 1'b0;
    end else begin
      ch_ren     <= SEL_NONE;
      ch_wen     <= SEL_NONE;
      ch_wdata   <= '0;
      clear_intr <= 1'b0;
      err_mode   <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state  <= RD_CTRL;
            ch_ren <= SEL_CTRL;
          end
        end

        RD_CTRL: begin
          ctrl_q   <= ch_rdata[31:15];
          state    <= RD_DATA;
          ch_ren   <= SEL_DATA;
          // The drop decision is known as soon as CTRL is sampled. The
          // pulse therefore lands in the RD_DATA cycle.
          err_mode <= (ch_rdata[30:29] == 2'b00);
        end

        RD_DATA: begin
          state      <= ACK;
          ch_wen     <= SEL_CTRL;
          ch_wdata   <= {ctrl_q, 1'b1, 14'b0};
          clear_intr <= 1'b1;
        end

        ACK: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a
  // power of two.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset. The pointers and count define
  // validity, and the head outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{mode: ctrl_q.mode, len: ctrl_q.len, data: ch_rdata};
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation. The head is read combinationally from the read
  // pointer and reads 0 when empty, including straight after reset.
  // ---------------------------------------------------------------------------
  // NOTE: outputs get a default before the conditional so always_comb
  // cannot infer a latch.
  always_comb begin
    out_data = '0;
    out_mode = '0;
    out_len  = '0;
    if (out_valid) begin
      out_data = mem[rd_ptr].data;
      out_mode = mem[rd_ptr].mode;
      out_len  = mem[rd_ptr].len;
    end
  end

endmodule

// File: tb/tb_mailbox_rx_agent.sv
// -----------------------------------------------------------------------------
// tb_mailbox_rx_agent
//
// Testbench for mailbox_rx_agent. It contains three parts:
//   - a mailbox channel model (CTRL/DATA registers and INT_bit) that answers
//     the agent's register port;
//   - a transaction-level reference: a queue of buffered messages and the
//     cycle offset inside the current fetch. Every negedge it is compared
//     against all DUT outputs;
//   - directed scenarios with hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_mailbox_rx_agent;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic          int_flag;
  logic [2:0]    ch_ren;
  logic [31:0]   ch_rdata;
  logic [2:0]    ch_wen;
  logic [31:0]   ch_wdata;
  logic          clear_intr;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [1:0]    out_mode;
  logic [13:0]   out_len;
  logic [AW:0]   fifo_count;
  logic          busy;
  logic          err_mode;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mailbox_rx_agent #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .int_flag   (int_flag),
    .ch_ren     (ch_ren),
    .ch_rdata   (ch_rdata),
    .ch_wen     (ch_wen),
    .ch_wdata   (ch_wdata),
    .clear_intr (clear_intr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_mode   (out_mode),
    .out_len    (out_len),
    .fifo_count (fifo_count),
    .busy       (busy),
    .err_mode   (err_mode)
  );

  // ---------------------------------------------------------------------------
  // Channel model. It is not affected by the agent's reset.
  // ---------------------------------------------------------------------------
  logic [31:0] ch_ctrl = '0;
  logic [31:0] ch_data = '0;
  logic        int_bit = 1'b0;
  logic [31:0] post_ctrl = '0;
  logic [31:0] post_data = '0;
  logic        post_tog = 1'b0;
  logic        post_seen = 1'b0;

  assign int_flag = ch_ctrl[31] & int_bit;
  assign ch_rdata = (ch_ren == 3'b001) ? ch_ctrl :
                    (ch_ren == 3'b010) ? ch_data : 32'h0;

  always @(posedge clk) begin
    if (clear_intr) int_bit <= 1'b0;
    if (ch_wen == 3'b001) ch_ctrl <= ch_wdata;
    if (post_tog != post_seen) begin
      post_seen <= post_tog;
      ch_ctrl   <= post_ctrl;
      ch_data   <= post_data;
      int_bit   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model. step counts the cycles since a fetch began (0 = none).
  // The queue holds the messages the core has not yet taken.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  m;
    logic [13:0] l;
  } ent_t;

  ent_t        q[$];
  int          step = 0;
  logic [31:0] m_ctrl = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step <= 0;
      q.delete();
    end else begin
      automatic bit take = (q.size() > 0) && out_ready;
      automatic bit go   = (step == 0) && en && int_flag && (q.size() < DEPTH);
      automatic ent_t e;
      if (take) void'(q.pop_front());
      if (step == 2 && m_ctrl[30:29] != 2'b00) begin
        e.d = ch_data;
        e.m = m_ctrl[30:29];
        e.l = m_ctrl[28:15];
        q.push_back(e);
      end
      if (step == 1) m_ctrl <= ch_ctrl;
      if (step == 0) step <= go ? 1 : 0;
      else           step <= (step == 3) ? 0 : step + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    logic [2:0]  e_ren;
    logic [2:0]  e_wen;
    logic [31:0] e_wdata;
    ent_t        h;
    e_ren   = (step == 1) ? 3'b001 : (step == 2) ? 3'b010 : 3'b000;
    e_wen   = (step == 3) ? 3'b001 : 3'b000;
    e_wdata = (step == 3) ? {m_ctrl[31:15], 1'b1, 14'b0} : 32'h0;
    h       = (q.size() > 0) ? q[0] : '0;
    check("m.ch_ren",     32'(ch_ren),     32'(e_ren));
    check("m.ch_wen",     32'(ch_wen),     32'(e_wen));
    check("m.ch_wdata",   ch_wdata,        e_wdata);
    check("m.clear_intr", 32'(clear_intr), 32'(step == 3));
    check("m.err_mode",   32'(err_mode),   32'(step == 2 && m_ctrl[30:29] == 2'b00));
    check("m.busy",       32'(busy),       32'(step != 0));
    check("m.out_valid",  32'(out_valid),  32'(q.size() > 0));
    check("m.fifo_count", 32'(fifo_count), 32'(q.size()));
    check("m.out_data",   out_data,        h.d);
    check("m.out_mode",   32'(out_mode),   32'(h.m));
    check("m.out_len",    32'(out_len),    32'(h.l));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] mk_ctrl(input logic [1:0] mode, input logic [13:0] len);
    return {1'b1, mode, len, 15'h0};
  endfunction

  task automatic post(input logic [31:0] c, input logic [31:0] d);
    int k = 0;
    while (int_flag && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("post int clear", 32'(int_flag), 32'd0);
    post_ctrl = c;
    post_data = d;
    post_tog  = ~post_tog;
  endtask

  task automatic wait_ren(input logic [2:0] v, input string nm);
    int k = 0;
    @(negedge clk);
    while (ch_ren != v && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(ch_ren), 32'(v));
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    @(negedge clk);
    while ((busy || int_flag) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'({busy, int_flag}), 32'd0);
  endtask

  task automatic pop_expect(input logic [31:0] d, input string nm);
    @(negedge clk);
    check({nm, " valid"}, 32'(out_valid), 32'd1);
    check(nm, out_data, d);
    #1 out_ready = 1'b1;
    @(negedge clk);
    #1 out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  logic [31:0] bp_data [5];
  logic [31:0] sp_data [4];

  initial begin
    bp_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
    sp_data = '{32'h3000_0001, 32'h3000_0002, 32'h3000_0003, 32'h3000_0004};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst ch_ren", 32'(ch_ren), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst fifo_count", 32'(fifo_count), 32'd0);
    check("rst out_data", out_data, 32'd0);
    #1 rstn = 1'b1;
    en = 1'b1;

    // Single message: mode 01, len 5
    post(32'hA002_8000, 32'hDEAD_BEEF);
    wait_ren(3'b001, "single ren ctrl");
    @(negedge clk);
    check("single ren data", 32'(ch_ren), 32'h2);
    @(negedge clk);
    check("single wen", 32'(ch_wen), 32'h1);
    check("single wdata", ch_wdata, 32'hA002_C000);
    check("single clear_intr", 32'(clear_intr), 32'd1);
    check("single out_data", out_data, 32'hDEAD_BEEF);
    check("single out_mode", 32'(out_mode), 32'd1);
    check("single out_len", 32'(out_len), 32'd5);
    wait_idle("single idle");
    pop_expect(32'hDEAD_BEEF, "single pop");

    // Backpressure: four accepted, fifth pending until a pop
    for (int i = 0; i < 4; i++) begin
      post(mk_ctrl(2'((i % 3) + 1), 14'(i + 1)), bp_data[i]);
      wait_idle("bp fill idle");
    end
    check("bp count full", 32'(fifo_count), 32'd4);
    post(mk_ctrl(2'b10, 14'd5), bp_data[4]);
    repeat (8) @(negedge clk);
    check("bp fifth pending busy", 32'(busy), 32'd0);
    check("bp fifth pending int", 32'(int_flag), 32'd1);
    check("bp count held", 32'(fifo_count), 32'd4);
    pop_expect(bp_data[0], "bp pop0");
    wait_idle("bp fifth idle");
    check("bp count refill", 32'(fifo_count), 32'd4);
    for (int i = 1; i < 5; i++) pop_expect(bp_data[i], "bp drain");

    // Simultaneous push and pop at occupancy 3, across pointer wrap
    for (int i = 0; i < 3; i++) begin
      post(mk_ctrl(2'b11, 14'(16 + i)), sp_data[i]);
      wait_idle("sp fill idle");
    end
    post(mk_ctrl(2'b01, 14'd19), sp_data[3]);
    wait_ren(3'b010, "sp ren data");
    #1 out_ready = 1'b1;
    @(negedge clk);
    #1 out_ready = 1'b0;
    check("sp count", 32'(fifo_count), 32'd3);
    check("sp head", out_data, sp_data[1]);
    wait_idle("sp idle");
    for (int i = 1; i < 4; i++) pop_expect(sp_data[i], "sp drain");

    // Mode 00: dropped, still acknowledged
    post(32'h8003_8000, 32'hBADC_0DE0);
    wait_ren(3'b010, "m0 ren data");
    check("m0 err_mode", 32'(err_mode), 32'd1);
    @(negedge clk);
    check("m0 clear_intr", 32'(clear_intr), 32'd1);
    check("m0 wdata", ch_wdata, 32'h8003_C000);
    wait_idle("m0 idle");
    check("m0 count", 32'(fifo_count), 32'd0);

    // Enable gating
    #1 en = 1'b0;
    post(mk_ctrl(2'b10, 14'd33), 32'h0E0E_0E0E);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("en gated ren", 32'(ch_ren), 32'd0);
    end
    #1 en = 1'b1;
    wait_ren(3'b001, "en ren ctrl");
    #1 en = 1'b0;
    wait_idle("en drop idle");
    check("en drop count", 32'(fifo_count), 32'd1);
    check("en drop data", out_data, 32'h0E0E_0E0E);
    #1 en = 1'b1;
    pop_expect(32'h0E0E_0E0E, "en pop");

    // Asynchronous reset during RD_DATA
    post(32'hE004_8000, 32'hCAFE_F00D);
    wait_ren(3'b010, "rst ren data");
    #1 rstn = 1'b0;
    #1;
    check("arst ch_ren", 32'(ch_ren), 32'd0);
    check("arst busy", 32'(busy), 32'd0);
    check("arst out_valid", 32'(out_valid), 32'd0);
    check("arst fifo_count", 32'(fifo_count), 32'd0);
    check("arst int kept", 32'(int_flag), 32'd1);
    @(negedge clk);
    #1 rstn = 1'b1;
    wait_ren(3'b001, "refetch ren ctrl");
    wait_idle("refetch idle");
    check("refetch count", 32'(fifo_count), 32'd1);
    check("refetch mode", 32'(out_mode), 32'd3);
    check("refetch len", 32'(out_len), 32'd9);
    pop_expect(32'hCAFE_F00D, "refetch pop");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
